// File: rtl/conv_enc_k7.sv
// conv_enc_k7: rate-1/2, K=7 feedforward convolutional encoder (G0=171o, G1=133o).
// Serial bits in, one coded pair out per bit, followed by K-1 zero tail pairs
// per frame so every frame starts and ends in state 0.
// Optional build macro CONV_ENC_PUNCT_EN: rate-2/3 puncturing (G0:11, G1:10)
// with an extra tx_mask output.
module conv_enc_k7 #(
   parameter int             K  = 7,
   parameter logic [K-1:0]   G0 = 7'o171,
   parameter logic [K-1:0]   G1 = 7'o133
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] tx_pair,
`ifdef CONV_ENC_PUNCT_EN
   output logic [1:0] tx_mask,
`endif
   output logic       tx_last
);

   localparam int M  = K - 1;
   localparam int TW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic {S_DATA, S_TAIL} state_t;

   state_t          state;
   logic [M-1:0]    sr;        // sr[M-1] is the most recent bit
   logic [TW-1:0]   tail_cnt;
   logic            can_load;  // output register empty or draining this cycle
   logic            load;
   logic            cur;
   logic [K-1:0]    w;
   logic            p0, p1;
   logic            tail_end;
`ifdef CONV_ENC_PUNCT_EN
   logic            phase;
`endif

   // Handshake, encoding window and parity.
   always_comb begin
      can_load = !out_valid || out_ready;
      in_ready = (state == S_DATA) && can_load;
      load     = (state == S_DATA) ? (in_valid && can_load) : can_load;
      cur      = (state == S_DATA) ? in_bit : 1'b0;
      w        = {cur, sr};
      p0       = ^(w & G0);
      p1       = ^(w & G1);
      tail_end = (state == S_TAIL) && (tail_cnt == TW'(M - 1));
   end

   // Output register, shift register and framing FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_DATA;
         sr        <= '0;
         tail_cnt  <= '0;
         out_valid <= 1'b0;
         tx_pair   <= 2'b00;
         tx_last   <= 1'b0;
`ifdef CONV_ENC_PUNCT_EN
         tx_mask   <= 2'b00;
         phase     <= 1'b0;
`endif
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (load) begin
            out_valid <= 1'b1;
            sr        <= {cur, sr[M-1:1]};
            tx_last   <= tail_end;
`ifdef CONV_ENC_PUNCT_EN
            // Phase restarts at 0 after the final tail pair, i.e. at frame start.
            tx_pair   <= phase ? {1'b0, p0} : {p1, p0};
            tx_mask   <= phase ? 2'b01 : 2'b11;
            phase     <= tail_end ? 1'b0 : ~phase;
`else
            tx_pair   <= {p1, p0};
`endif
            case (state)
               S_DATA: begin
                  if (in_last) begin
                     state    <= S_TAIL;
                     tail_cnt <= '0;
                  end
               end
               S_TAIL: begin
                  if (tail_end) begin
                     state    <= S_DATA;
                     tail_cnt <= '0;
                  end else begin
                     tail_cnt <= tail_cnt + TW'(1);
                  end
               end
               default: state <= S_DATA;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_enc_k7.sv
// Directed bench for conv_enc_k7: impulse, all-zero frame, backpressure,
// back-to-back frames and reset mid-tail. Builds with or without CONV_ENC_PUNCT_EN.
module tb_conv_enc_k7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_bit, in_last;
   logic       out_valid, out_ready;
   logic [1:0] tx_pair;
   logic       tx_last;
`ifdef CONV_ENC_PUNCT_EN
   logic [1:0] tx_mask;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0] got_pair [64];
   logic       got_last [64];
   int         out_cyc  [64];
   int         acc_cyc  [32];
   int         got_cnt;
`ifdef CONV_ENC_PUNCT_EN
   logic [1:0] got_mask [64];
   logic [1:0] exp_mask [7] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
   logic [1:0] exp_imp  [7] = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 2'b11};
`else
   logic [1:0] exp_imp  [7] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
`endif

   always #5 clk = ~clk;

   conv_enc_k7 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .tx_pair   (tx_pair),
`ifdef CONV_ENC_PUNCT_EN
      .tx_mask   (tx_mask),
`endif
      .tx_last   (tx_last)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one bit stream and collects transfers. Starts and ends at posedge+1.
   // rdy_mode 0: out_ready always 1; 1: pattern 1,0,0 repeating.
   task automatic run(input int nb, input logic [31:0] bits, input logic [31:0] lasts,
                      input int rdy_mode, input int nlast, input int stop_at, input int budget);
      int         ib, nl;
      logic       stalled, done;
      logic [1:0] prev;
      ib = 0; nl = 0; stalled = 1'b0; prev = 2'b00; got_cnt = 0; done = 1'b0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         in_valid  = (ib < nb);
         in_bit    = (ib < nb) ? bits[ib] : 1'b0;
         in_last   = (ib < nb) ? lasts[ib] : 1'b0;
         #1;
         if (stalled) begin
            chk("hold_pair", tx_pair, prev);
            chk("hold_valid", out_valid, 1);
         end
         if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
         if (in_valid && in_ready) begin
            acc_cyc[ib] = cyc;
            ib++;
         end
         if (out_valid && out_ready) begin
            got_pair[got_cnt] = tx_pair;
            got_last[got_cnt] = tx_last;
`ifdef CONV_ENC_PUNCT_EN
            got_mask[got_cnt] = tx_mask;
`endif
            out_cyc[got_cnt]  = cyc;
            got_cnt++;
            if (tx_last) nl++;
         end
         stalled = out_valid && !out_ready;
         prev    = tx_pair;
         @(posedge clk); #1;
         if (nl == nlast || got_cnt == stop_at) begin
            done = 1'b1;
            break;
         end
      end
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      chk("run_done", done, 1);
   endtask

   task automatic chk_impulse(input string tag, input int base);
      for (int i = 0; i < 7; i++) begin
         chk({tag, "_pair"}, got_pair[base+i], exp_imp[i]);
         chk({tag, "_last"}, got_last[base+i], (i == 6));
`ifdef CONV_ENC_PUNCT_EN
         chk({tag, "_mask"}, got_mask[base+i], exp_mask[i]);
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_tx_pair", tx_pair, 0);
      chk("rst_tx_last", tx_last, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef CONV_ENC_PUNCT_EN
      chk("rst_tx_mask", tx_mask, 0);
`endif
      @(posedge clk); #1;

      // Impulse
      run(1, 32'h1, 32'h1, 0, 1, 64, 50);
      chk("imp_count", got_cnt, 7);
      chk_impulse("imp", 0);

      // All-zero frame of 20 bits: 26 zero pairs, back-to-back
      run(20, 32'h0, 32'h1 << 19, 0, 1, 64, 100);
      chk("zero_count", got_cnt, 26);
      for (int i = 0; i < 26; i++) begin
         chk("zero_pair", got_pair[i], 0);
         chk("zero_last", got_last[i], (i == 25));
         chk("zero_nobubble", out_cyc[i], out_cyc[0] + i);
      end

      // Backpressure
      run(1, 32'h1, 32'h1, 1, 1, 64, 100);
      chk("bp_count", got_cnt, 7);
      chk_impulse("bp", 0);

      // Back-to-back single-bit frames
      run(2, 32'h3, 32'h3, 0, 2, 64, 100);
      chk("b2b_count", got_cnt, 14);
      chk_impulse("b2b_f1", 0);
      chk_impulse("b2b_f2", 7);
      chk("b2b_order", (acc_cyc[1] >= out_cyc[6]), 1);
      chk("b2b_nobubble", out_cyc[13], out_cyc[0] + 13);

      // Reset after the 3rd impulse pair
      run(1, 32'h1, 32'h1, 0, 9, 3, 50);
      chk("mid_count", got_cnt, 3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_pair", tx_pair, 0);
      chk("mid_rst_ready", in_ready, 1);
      @(posedge clk); #1;
      run(1, 32'h1, 32'h1, 0, 1, 64, 50);
      chk("mid_count2", got_cnt, 7);
      chk_impulse("mid", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_enc_k7.md
Name: conv_enc_k7

Overview:
- Rate-1/2, constraint-length-7 feedforward convolutional encoder; transmit-side counterpart of the 64-state hard-decision Viterbi decoder.
- Accepts a serial bit stream framed by a last flag and emits one coded pair per input bit, so pairs line up with the decoder's branch-metric inputs.
- Appends K-1 zero tail bits per frame, so every frame starts and ends in state 0.

Parameters:
- K, 7, constraint length; the shift register holds K-1 = 6 bits.
- G0, 7'o171, generator polynomial for tx_pair[0].
- G1, 7'o133, generator polynomial for tx_pair[1].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  in_bit/in_last valid.
- in_ready  out  1  encoder accepts input this cycle.
- in_bit  in  1  data bit.
- in_last  in  1  marks the final data bit of a frame.
- out_valid  out  1  tx_pair/tx_last valid.
- out_ready  in  1  downstream accepts the output this cycle.
- tx_pair  out  2  coded pair: [0] = G0 parity, [1] = G1 parity.
- tx_last  out  1  marks the final (tail) pair of a frame.

Interface (already decided):
- One clock, clk.
- Reset rst_n is synchronous and active-low.

Behaviour:
- Encoding window: w[6] = current bit (data or tail zero), w[5:0] = shift register, w[5] most recent.
  - tx_pair[0] = XOR-reduce(w & G0); tx_pair[1] = XOR-reduce(w & G1).
  - On every input or tail transfer, the shift register shifts in w[6].
- Output is a one-entry register:
  - Pair appears one cycle after its input handshake.
  - A transfer occurs when out_valid && out_ready.
  - The register may load only when it is empty or being drained in the same cycle (full throughput, no bubbles).
- While out_valid && !out_ready: tx_pair, tx_last and out_valid hold stable.
- FSM states:
  - DATA (reset state): in_ready = !out_valid || out_ready. On accept, load the pair and shift in in_bit. If in_last, go to TAIL with tail_cnt = 0.
  - TAIL: in_ready = 0. When the output register can load, encode w[6] = 0, shift, and increment tail_cnt. The load with tail_cnt = K-2 sets tx_last = 1 and returns to DATA.
- Frame of N data bits yields N+6 pairs; tx_last is asserted only on the last pair.
- After the tail, the shift register is all-zero; the next frame's first bit is encoded from state 0 with no explicit clear.
- in_bit is ignored when in_valid = 0. in_last = 1 on a 1-bit frame is legal.
- in_valid asserted during TAIL is not accepted; upstream holds it.
- Reset, at any time including mid-frame or mid-tail:
  - shift register = 0, state = DATA, tail_cnt = 0;
  - out_valid = 0, tx_pair = 2'b00, tx_last = 0;
  - in_ready = 1 in the first cycle after reset deasserts.
- Any pending output is discarded; no partial tail is emitted.

Optional Feature:
- Macro: CONV_ENC_PUNCT_EN.
- When defined:
  - Rate-2/3 puncturing with pattern G0:11, G1:10.
  - Adds output tx_mask[1:0] (bit = 1 means the tx_pair bit is transmitted).
  - A phase bit toggles on every output load, data and tail alike, and resets to 0 at reset and at frame start.
  - Phase 0: tx_mask = 2'b11. Phase 1: tx_mask = 2'b01, and tx_pair[1] is forced to 0.
  - tx_mask resets to 2'b00.
- When undefined: no tx_mask port; every pair is full rate.

Test Plan:
- Impulse:
  - Stimulus: reset, then one input {in_bit = 1, in_last = 1}, out_ready = 1.
  - Response: 7 pairs, tx_pair = 11, 01, 11, 11, 00, 10, 11; tx_last only on the 7th.
- All-zero frame:
  - Stimulus: 20 zero bits, in_last on the 20th.
  - Response: 26 pairs, all 00; tx_last on pair 26; 26 consecutive-cycle outputs with no bubbles.
- Backpressure:
  - Stimulus: impulse frame with out_ready toggled 1,0,0,1,...
  - Response: same 7-pair sequence; tx_pair stable while stalled; in_ready = 0 while out_valid && !out_ready.
- Back-to-back frames:
  - Stimulus: frame {1, last}, then frame {1, last} offered immediately.
  - Response: the second frame is accepted only after the first frame's tx_last transfer, and its pairs repeat the impulse sequence (state 0 restored).
- Reset mid-tail:
  - Stimulus: rst_n = 0 for 1 cycle after the 3rd impulse pair.
  - Response: out_valid = 0 next cycle; a following {1, last} frame yields the exact impulse sequence.
- Puncture (CONV_ENC_PUNCT_EN):
  - Stimulus: impulse frame.
  - Response: tx_mask = 11, 01, 11, 01, 11, 01, 11; tx_pair = 11, 01, 11, 01, 00, 00, 11.
